mem_wb_stage_reg: RTL and testbench

Pipeline register between the MEM and WB stages of the five-stage LEGv8 core. It captures the ALU result, the data-memory read word and the writeback controls at each rising clock edge. It presents them to the WB-stage 64-bit 2:1 writeback select (ALU result vs. memory data, chosen by `wb_mem_to_reg`) and to the register file write port. It also supports stall, flush/bubble insertion, XZR write suppression and a retired-instruction counter.

---
 rtl/mem_wb_stage_reg.sv | 97 +++++++++
 tb/tb_mem_wb_stage_reg.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_reg.sv
// rtl/mem_wb_stage_reg.sv - MEM/WB pipeline register with stall, flush, XZR write suppression and retire counter
module mem_wb_stage_reg #(
    parameter int DATA_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ZERO_REG       = 31
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      mem_valid,
    input  logic [DATA_WIDTH-1:0]     mem_alu_result,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_mem_to_reg,
    input  logic                      mem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic                      stall,
    input  logic                      flush,
    output logic                      wb_valid,
    output logic [DATA_WIDTH-1:0]     wb_alu_result,
    output logic [DATA_WIDTH-1:0]     wb_rdata,
    output logic                      wb_mem_to_reg,
    output logic                      wb_reg_write,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [63:0]               retire_count
);

    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_IDX = REG_ADDR_WIDTH'(ZERO_REG);

    logic                      valid_q,      valid_d;
    logic [DATA_WIDTH-1:0]     alu_result_q, alu_result_d;
    logic [DATA_WIDTH-1:0]     rdata_q,      rdata_d;
    logic                      mem_to_reg_q, mem_to_reg_d;
    logic                      reg_write_q,  reg_write_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,         rd_d;
    logic [63:0]               retire_q,     retire_d;
    logic                      retiring;

    // Next-state selection: flush beats stall, stall beats a normal load
    always_comb begin
        valid_d      = valid_q;
        alu_result_d = alu_result_q;
        rdata_d      = rdata_q;
        mem_to_reg_d = mem_to_reg_q;
        reg_write_d  = reg_write_q;
        rd_d         = rd_q;
        if (flush) begin
            valid_d      = 1'b0;
            alu_result_d = '0;
            rdata_d      = '0;
            mem_to_reg_d = 1'b0;
            reg_write_d  = 1'b0;
            rd_d         = '0;
        end else if (!stall) begin
            valid_d      = mem_valid;
            alu_result_d = mem_alu_result;
            rdata_d      = mem_rdata;
            mem_to_reg_d = mem_mem_to_reg;
            reg_write_d  = mem_valid & mem_reg_write & (mem_rd != ZERO_IDX);
            rd_d         = mem_rd;
        end
    end

    // The resident instruction leaves WB whenever the register is not held; a flush still retires it
    always_comb begin
        retiring = valid_q & (flush | ~stall);
        retire_d = retiring ? retire_q + 64'd1 : retire_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q      <= 1'b0;
            alu_result_q <= '0;
            rdata_q      <= '0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            rd_q         <= '0;
            retire_q     <= '0;
        end else begin
            valid_q      <= valid_d;
            alu_result_q <= alu_result_d;
            rdata_q      <= rdata_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            rd_q         <= rd_d;
            retire_q     <= retire_d;
        end
    end

    assign wb_valid      = valid_q;
    assign wb_alu_result = alu_result_q;
    assign wb_rdata      = rdata_q;
    assign wb_mem_to_reg = mem_to_reg_q;
    assign wb_reg_write  = reg_write_q;
    assign wb_rd         = rd_q;
    assign retire_count  = retire_q;

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// tb/tb_mem_wb_stage_reg.sv - scoreboard bench for mem_wb_stage_reg
module tb_mem_wb_stage_reg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid;
    logic [63:0] mem_alu_result;
    logic [63:0] mem_rdata;
    logic        mem_mem_to_reg;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic        stall;
    logic        flush;
    logic        wb_valid;
    logic [63:0] wb_alu_result;
    logic [63:0] wb_rdata;
    logic        wb_mem_to_reg;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [63:0] retire_count;

    mem_wb_stage_reg dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_valid      (mem_valid),
        .mem_alu_result (mem_alu_result),
        .mem_rdata      (mem_rdata),
        .mem_mem_to_reg (mem_mem_to_reg),
        .mem_reg_write  (mem_reg_write),
        .mem_rd         (mem_rd),
        .stall          (stall),
        .flush          (flush),
        .wb_valid       (wb_valid),
        .wb_alu_result  (wb_alu_result),
        .wb_rdata       (wb_rdata),
        .wb_mem_to_reg  (wb_mem_to_reg),
        .wb_reg_write   (wb_reg_write),
        .wb_rd          (wb_rd),
        .retire_count   (retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        v;
        logic [63:0] alu;
        logic [63:0] rdata;
        logic        m2r;
        logic        rw;
        logic [4:0]  rd;
        logic [63:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   errors = 0;

    // Monitor: every cycle the register presents a new state, compare it with the oldest expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests++;
            if (wb_valid !== e.v || wb_alu_result !== e.alu || wb_rdata !== e.rdata ||
                wb_mem_to_reg !== e.m2r || wb_reg_write !== e.rw || wb_rd !== e.rd ||
                retire_count !== e.cnt) begin
                errors++;
                $display("FAIL step%0d: got v=%0b alu=%h rdata=%h m2r=%0b rw=%0b rd=%0d cnt=%h; want v=%0b alu=%h rdata=%h m2r=%0b rw=%0b rd=%0d cnt=%h",
                         e.id, wb_valid, wb_alu_result, wb_rdata, wb_mem_to_reg, wb_reg_write, wb_rd, retire_count,
                         e.v, e.alu, e.rdata, e.m2r, e.rw, e.rd, e.cnt);
            end
        end
    end

    int step_id = 0;

    // Drive one edge worth of inputs and queue the outputs expected after that edge
    task automatic step(input logic rn, input logic st, input logic fl,
                        input logic mv, input logic [63:0] alu, input logic [63:0] rdat,
                        input logic m2r, input logic rw, input logic [4:0] rd,
                        input logic ev, input logic [63:0] ealu, input logic [63:0] erdata,
                        input logic em2r, input logic erw, input logic [4:0] erd,
                        input logic [63:0] ecnt);
        exp_t e;
        reset_n        = rn;
        stall          = st;
        flush          = fl;
        mem_valid      = mv;
        mem_alu_result = alu;
        mem_rdata      = rdat;
        mem_mem_to_reg = m2r;
        mem_reg_write  = rw;
        mem_rd         = rd;
        step_id++;
        e.id = step_id; e.v = ev; e.alu = ealu; e.rdata = erdata;
        e.m2r = em2r; e.rw = erw; e.rd = erd; e.cnt = ecnt;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk);
        #1;
        // rn st fl mv alu rdata m2r rw rd | v alu rdata m2r rw rd cnt
        // reset held for two edges while MEM carries a valid instruction
        step(0,0,0, 1,64'hDEAD_BEEF,0,0,0,0,       0,0,0,0,0,0, 0);
        step(0,0,0, 1,64'hDEAD_BEEF,0,0,0,0,       0,0,0,0,0,0, 0);
        // first edge after release loads normally
        step(1,0,0, 1,64'hDEAD_BEEF,0,0,0,0,       1,64'hDEAD_BEEF,0,0,0,0, 0);
        // load with memory writeback to x5; previous valid retires
        step(1,0,0, 1,0,64'h1234,1,1,5,            1,0,64'h1234,1,1,5, 1);
        // write to XZR is suppressed but still a valid instruction
        step(1,0,0, 1,64'h7,0,0,1,31,              1,64'h7,0,0,0,31, 2);
        // load A, then stall three edges with B waiting
        step(1,0,0, 1,64'hA,0,0,1,2,               1,64'hA,0,0,1,2, 3);
        step(1,1,0, 1,64'hB,0,0,1,3,               1,64'hA,0,0,1,2, 3);
        step(1,1,0, 1,64'hB,0,0,1,3,               1,64'hA,0,0,1,2, 3);
        step(1,1,0, 1,64'hB,0,0,1,3,               1,64'hA,0,0,1,2, 3);
        step(1,0,0, 1,64'hB,0,0,1,3,               1,64'hB,0,0,1,3, 4);
        // flush together with stall while full: bubble, outgoing instruction retires
        step(1,1,1, 1,64'hC,64'hC,1,1,7,           0,0,0,0,0,0, 5);
        // flush while empty: nothing retires
        step(1,0,1, 1,64'hD,0,0,1,8,               0,0,0,0,0,0, 5);
        // invalid instruction: fields captured, write enable forced low
        step(1,0,0, 0,64'hE,64'hF,1,1,4,           0,64'hE,64'hF,1,0,4, 5);
        // stall while empty holds everything
        step(1,1,0, 1,64'h99,0,0,1,9,              0,64'hE,64'hF,1,0,4, 5);
        step(1,0,0, 1,64'h11,0,0,1,1,              1,64'h11,0,0,1,1, 5);
        // counter wrap: preload all ones, the valid resident instruction retires
        force dut.retire_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.retire_q;
        step(1,0,0, 0,0,0,0,0,0,                   0,0,0,0,0,0, 0);
        step(1,0,0, 1,64'h22,64'h23,0,1,10,        1,64'h22,64'h23,0,1,10, 0);
        // reset asserted during stall and flush wins
        step(0,1,1, 1,64'h44,0,0,1,12,             0,0,0,0,0,0, 0);
        step(1,0,0, 1,64'h33,0,0,1,6,              1,64'h33,0,0,1,6, 0);
        step(1,0,0, 0,0,0,0,0,0,                   0,0,0,0,0,0, 1);
        // every expectation must have been consumed by now
        tests++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
